// File: rtl/coin_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : coin_tracker_if
//  Description : Bundle between the level logic (master) and the coin
//                tracker (slave): coin/goal/death flags in, level-flow out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface coin_tracker_if #(
    parameter int NUM_COINS  = 4,
    parameter int NUM_LEVELS = 3
);
    localparam int CW = ($clog2(NUM_COINS + 1) > 0) ? $clog2(NUM_COINS + 1) : 1;
    localparam int LW = ($clog2(NUM_LEVELS) > 0) ? $clog2(NUM_LEVELS) : 1;

    logic [NUM_COINS-1:0] collected;
    logic                 in_goal;
    logic                 player_dead;
    logic                 refresh;
    logic [LW-1:0]        level;
    logic [CW-1:0]        coins_left;
    logic                 all_collected;
    logic                 level_done;
    logic                 game_won;
    logic [7:0]           deaths;

    modport master (
        output collected,
        output in_goal,
        output player_dead,
        input  refresh,
        input  level,
        input  coins_left,
        input  all_collected,
        input  level_done,
        input  game_won,
        input  deaths
    );

    modport slave (
        input  collected,
        input  in_goal,
        input  player_dead,
        output refresh,
        output level,
        output coins_left,
        output all_collected,
        output level_done,
        output game_won,
        output deaths
    );
endinterface
`default_nettype wire

// File: rtl/coin_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : coin_tracker
//  Description : Level-progress controller: detects death / level clear,
//                pulses refresh to re-arm coins, advances the level index and
//                flags game completion. Define COIN_TRACKER_DEATHS_EN to build
//                the saturating 8-bit death counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_tracker #(
    parameter int NUM_COINS  = 4,
    parameter int NUM_LEVELS = 3
) (
    input  wire             frame_clk,
    input  wire             Reset,
    coin_tracker_if.slave   tif
);
    localparam int CW = ($clog2(NUM_COINS + 1) > 0) ? $clog2(NUM_COINS + 1) : 1;
    localparam int LW = ($clog2(NUM_LEVELS) > 0) ? $clog2(NUM_LEVELS) : 1;

    localparam logic [LW-1:0] c_LAST_LEVEL = LW'(NUM_LEVELS - 1);
    localparam logic [CW-1:0] c_NUM_COINS  = CW'(NUM_COINS);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_PLAY   = 2'd2,
        ST_WON    = 2'd3
    } state_t;

    state_t         r_state;
    logic           r_refresh;
    logic [LW-1:0]  r_level;
    logic [CW-1:0]  r_coins_left;
    logic           r_all_collected;
    logic           r_level_done;
    logic           r_game_won;
    logic [7:0]     r_deaths;

    logic [CW-1:0]  w_popcount;
    logic [CW-1:0]  w_coins_left;
    logic           w_all_collected;

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            w_popcount = w_popcount + CW'(tif.collected[i]);
        end
    end

    assign w_coins_left    = c_NUM_COINS - w_popcount;
    assign w_all_collected = &tif.collected;

    // Coin status tracks the inputs in every state, independent of the FSM.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_coins_left    <= c_NUM_COINS;
            r_all_collected <= 1'b0;
        end else begin
            r_coins_left    <= w_coins_left;
            r_all_collected <= w_all_collected;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state      <= ST_LOAD;
            r_refresh    <= 1'b0;
            r_level      <= '0;
            r_level_done <= 1'b0;
            r_game_won   <= 1'b0;
        end else begin
            r_refresh    <= 1'b0;
            r_level_done <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    r_refresh <= 1'b1;
                    r_state   <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    r_state <= ST_PLAY;
                end
                ST_PLAY: begin
                    // Death outranks a simultaneous goal.
                    if (tif.player_dead) begin
                        r_state <= ST_LOAD;
                    end else if (tif.in_goal && r_all_collected) begin
                        r_level_done <= 1'b1;
                        if (r_level < c_LAST_LEVEL) begin
                            r_level <= r_level + LW'(1);
                            r_state <= ST_LOAD;
                        end else begin
                            r_game_won <= 1'b1;
                            r_state    <= ST_WON;
                        end
                    end
                end
                ST_WON: begin
                    r_state <= ST_WON;
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

`ifdef COIN_TRACKER_DEATHS_EN
    logic w_death_evt;
    assign w_death_evt = (r_state == ST_PLAY) && tif.player_dead;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_deaths <= 8'd0;
        end else if (w_death_evt && (r_deaths != 8'hFF)) begin
            r_deaths <= r_deaths + 8'd1;
        end
    end
`else
    assign r_deaths = 8'd0;
`endif

    assign tif.refresh       = r_refresh;
    assign tif.level         = r_level;
    assign tif.coins_left    = r_coins_left;
    assign tif.all_collected = r_all_collected;
    assign tif.level_done    = r_level_done;
    assign tif.game_won      = r_game_won;
    assign tif.deaths        = r_deaths;

endmodule
`default_nettype wire

// File: tb/tb_coin_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_tracker
//  Description : Scoreboard bench for coin_tracker: an event-timing reference
//                model queues expected outputs, a monitor compares each frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_tracker;
    localparam int NC = 4;
    localparam int NL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    coin_tracker_if #(.NUM_COINS(NC), .NUM_LEVELS(NL)) tif ();

    coin_tracker #(.NUM_COINS(NC), .NUM_LEVELS(NL)) dut (
        .frame_clk (clk),
        .Reset     (rst),
        .tif       (tif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int refresh;
        int level_done;
        int level;
        int coins_left;
        int all_collected;
        int game_won;
        int deaths;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: edge count since reset, when the next refresh is due and
    // from which edge the player can act again.
    int m_edge, m_refresh_at, m_play_at;
    int m_level, m_won, m_deaths, m_ac, m_cl;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic step(input logic [NC-1:0] coll, input logic goal,
                        input logic dead, input logic rst_in);
        exp_t e;
        rst             = rst_in;
        tif.collected   = coll;
        tif.in_goal     = goal;
        tif.player_dead = dead;
        e.refresh    = 0;
        e.level_done = 0;
        if (rst_in) begin
            m_edge = 0; m_refresh_at = 1; m_play_at = 3;
            m_level = 0; m_won = 0; m_deaths = 0; m_ac = 0; m_cl = NC;
        end else begin
            m_edge++;
            if (m_edge == m_refresh_at) e.refresh = 1;
            if (!m_won && m_edge >= m_play_at) begin
                if (dead) begin
`ifdef COIN_TRACKER_DEATHS_EN
                    if (m_deaths < 255) m_deaths++;
`endif
                    m_refresh_at = m_edge + 1;
                    m_play_at    = m_edge + 3;
                end else if (goal && m_ac != 0) begin
                    e.level_done = 1;
                    if (m_level < NL - 1) begin
                        m_level++;
                        m_refresh_at = m_edge + 1;
                        m_play_at    = m_edge + 3;
                    end else begin
                        m_won = 1;
                    end
                end
            end
            m_ac = ($countones(coll) == NC) ? 1 : 0;
            m_cl = NC - $countones(coll);
        end
        e.level         = m_level;
        e.coins_left    = m_cl;
        e.all_collected = m_ac;
        e.game_won      = m_won;
        e.deaths        = m_deaths;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected record per frame edge, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("refresh",       int'(tif.refresh),       e.refresh);
                check("level_done",    int'(tif.level_done),    e.level_done);
                check("level",         int'(tif.level),         e.level);
                check("coins_left",    int'(tif.coins_left),    e.coins_left);
                check("all_collected", int'(tif.all_collected), e.all_collected);
                check("game_won",      int'(tif.game_won),      e.game_won);
                check("deaths",        int'(tif.deaths),        e.deaths);
            end
        end
    end

    initial begin
        logic [NC-1:0] rc;
        tif.collected   = '0;
        tif.in_goal     = 1'b0;
        tif.player_dead = 1'b0;

        // Reset and release
        repeat (2) step(4'b0000, 0, 0, 1);
        repeat (4) step(4'b0000, 0, 0, 0);

        // Collect coins, then enter goal
        step(4'b0111, 0, 0, 0);
        step(4'b1111, 0, 0, 0);
        step(4'b1111, 1, 0, 0);
        repeat (4) step(4'b1111, 0, 0, 0);

        // Goal without all coins does nothing
        repeat (10) step(4'b0011, 1, 0, 0);

        // Death and goal together: death wins
        step(4'b1111, 0, 0, 0);
        step(4'b1111, 1, 1, 0);
        repeat (4) step(4'b1111, 0, 0, 0);

        // Clear remaining levels through to WON
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1, 0, 0);
            repeat (3) step(4'b1111, 0, 0, 0);
        end
        repeat (3) step(4'b1111, 1, 1, 0);
        repeat (3) step(4'b0101, 1, 0, 0);

        // Reset out of WON
        step(4'b0000, 0, 0, 1);
        repeat (4) step(4'b0000, 0, 0, 0);

        // Sustained deaths toward saturation
        repeat (900) step(4'b0000, 0, 1, 0);
        repeat (3) step(4'b0000, 0, 0, 0);

        // Randomised play
        step(4'b0000, 0, 0, 1);
        for (int i = 0; i < 800; i++) begin
            rc = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom);
            step(rc, ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 149) == 0));
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/coin_tracker.md
# coin_tracker

Level-progress controller downstream of the per-level coin instances. Consumes the coins' `collected` flags, the player's goal-zone flag and death flag, and decides when the player has died or cleared the level. Issues the one-frame `refresh` pulse that re-arms the coins, advances the level index that drives the level ROM and coin positions, and flags game completion.

## Interface
- `NUM_COINS`, 4: number of coin instances per level (unused slots sit at position 0,0 and report collected).
- `NUM_LEVELS`, 3: number of levels; level index runs 0..NUM_LEVELS-1.
- Derived widths: `CW = $clog2(NUM_COINS+1)` and `LW = $clog2(NUM_LEVELS)`, minimum 1.

Ports:
- `frame_clk  in  1`: clock; one cycle per video frame.
- `Reset  in  1`: synchronous, active-high.
- `collected  in  NUM_COINS`: per-coin collected flags.
- `in_goal  in  1`: player overlaps the goal zone.
- `player_dead  in  1`: player hit an enemy this frame.
- `refresh  out  1`: one-cycle pulse that reloads coins and player for the current `level`.
- `level  out  LW`: current level index.
- `coins_left  out  CW`: `NUM_COINS` minus the popcount of `collected`.
- `all_collected  out  1`: every `collected` bit is set.
- `level_done  out  1`: one-cycle pulse when the level is cleared.
- `game_won  out  1`: the last level is cleared; sticky.
- `deaths  out  8`: saturating death counter (see Configuration).

## Operation
- FSM states: LOAD, SETTLE, PLAY, WON.
- **LOAD**
  - `refresh` is 1 for exactly this cycle.
  - Next state is SETTLE.
- **SETTLE**
  - Lasts one cycle.
  - During it, cleared coins re-assert `collected` for unused (0,0) slots.
  - `collected`, `in_goal` and `player_dead` are ignored.
  - Next state is PLAY.
- **PLAY**, evaluated in priority order:
  1. `player_dead` = 1: `deaths` increments, saturating at 255. Next state is LOAD; `level` is unchanged.
  2. `in_goal` & `all_collected` (registered value) with `level` < NUM_LEVELS-1: `level_done` pulses, `level` increments. Next state is LOAD.
  3. `in_goal` & `all_collected` with `level` = NUM_LEVELS-1: `level_done` pulses, `game_won` is set. Next state is WON.
  4. Otherwise stay in PLAY.
- **WON**
  - Terminal: all inputs are ignored, `level` holds, and `refresh` is never issued.
  - Only `Reset` exits this state.
- `in_goal` without `all_collected` has no effect.
- `coins_left` and `all_collected` are recomputed from `collected` every cycle in every state.
- `coins_left` is never negative, since the popcount is at most NUM_COINS.

## Timing
- All outputs are registered.
- Reset values:
  - State is LOAD.
  - `refresh`=0, `level`=0, `coins_left`=NUM_COINS, `all_collected`=0, `level_done`=0, `game_won`=0, `deaths`=0.
- After `Reset` deasserts:
  - `refresh`=1 on the first cycle.
  - SETTLE on the second cycle.
  - PLAY from the third cycle.
- `coins_left` / `all_collected` latency: 1 cycle from `collected`.
- The goal check uses the registered `all_collected`. A goal entered in the same cycle as the last coin is collected is therefore recognised one cycle later, provided `in_goal` is still high.
- Exit from PLAY to LOAD:
  - `level_done` and the `level` increment are registered on the cycle PLAY→LOAD is taken.
  - `refresh` follows one cycle later, with the new `level` already stable.
- From a death or clear in PLAY to the next PLAY: 3 cycles (LOAD, SETTLE, PLAY).
- `Reset` asserted in any state, including mid-LOAD or WON, forces the reset values on the next edge. A pending `refresh` or `level_done` pulse is dropped.
- `player_dead` and the goal condition in the same cycle: the death wins. There is no `level_done` and `level` is unchanged.
- `level` wrap-around cannot occur. The last level goes to WON instead of incrementing.

## Configuration
- `COIN_TRACKER_DEATHS_EN` defined:
  - The 8-bit `deaths` counter is implemented.
  - It increments on each PLAY-state death and saturates at 255.
- `COIN_TRACKER_DEATHS_EN` undefined:
  - `deaths` is tied to 0 and no counter register exists.
  - Death still triggers LOAD with `level` unchanged. All other behaviour is identical.

## Test plan
- Reset release, NUM_COINS=4, `collected`=0 → `refresh`=1 only on cycle 1, PLAY by cycle 3, `coins_left`=4, `level`=0.
- In PLAY, set `collected`=4'b0111 then 4'b1111 on the next cycle → `coins_left` reads 1, then 0, each one cycle after its input, and `all_collected`=1. Then `in_goal`=1 → `level_done` pulse, `level`=1, `refresh` pulse on the next cycle.
- `collected`=4'b0011 with `in_goal`=1 held for 10 cycles → no `level_done`, `level` stays 0, no `refresh`.
- `player_dead`=1 and `in_goal`=1 with all coins collected, same cycle → `deaths` goes 0→1, `level` unchanged, `refresh` one cycle later, no `level_done`.
- Clear levels 0, 1, 2 (NUM_LEVELS=3) → after the third clear `game_won`=1 and `level`=2, and further `player_dead` or `in_goal` produces no `refresh`. Assert `Reset` → `level`=0, `game_won`=0, `refresh` pulse after release.
- With the macro defined, drive 300 deaths → `deaths` saturates at 255. With the macro undefined, `deaths` stays 0 and each death still produces a `refresh`.
